freqdivider_prog: RTL

Runtime-programmable clock-enable divider for the music-box tone path: generalises the fixed-M divider by accepting a new divisor at run time, switching glitch-free at period boundaries, and producing a near-50 % square wave plus an optional one-cycle tick. It sits between the note sequencer, which loads divisors, and the buzzer/PWM output stage.

---
 rtl/freqdivider_prog_pkg.sv | 18 +
 rtl/freqdivider_prog_if.sv | 24 ++
 rtl/freqdivider_prog_reload.sv | 59 +++++
 rtl/freqdivider_prog.sv | 81 ++++++++
 4 files changed

// File: rtl/freqdivider_prog_pkg.sv
// Shared constants and types for the runtime-programmable clock-enable divider.
// FREQDIV_DIV_MIN and the default width are reused by the note sequencer.
package freqdivider_prog_pkg;

    localparam int FREQDIV_DIV_MIN   = 2;
    localparam int FREQDIV_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DIRECT,
        SRC_PEND
    } reload_src_e;

    function automatic int clamp_div_int(input int v);
        return (v < FREQDIV_DIV_MIN) ? FREQDIV_DIV_MIN : v;
    endfunction

endpackage

// File: rtl/freqdivider_prog_if.sv
// Sequencer-to-divider bundle: run enable, divisor load, busy flag and outputs.
// The tick signal exists only when FREQDIV_TICK_EN is defined.
interface freqdivider_prog_if
    import freqdivider_prog_pkg::*;
#(
    parameter int W = FREQDIV_W_DEFAULT
) ();

    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         div_busy;
    logic         clk_salida;
`ifdef FREQDIV_TICK_EN
    logic         tick;

    modport master (output en, div_in, div_load, input div_busy, clk_salida, tick);
    modport slave  (input en, div_in, div_load, output div_busy, clk_salida, tick);
`else
    modport master (output en, div_in, div_load, input div_busy, clk_salida);
    modport slave  (input en, div_in, div_load, output div_busy, clk_salida);
`endif

endinterface

// File: rtl/freqdivider_prog_reload.sv
// Divisor shadow register: holds a pending divisor until the next wrap, or applies
// it at once on a wrap edge or while idle. Output divisor is clamped to the minimum.
module freqdivider_prog_reload
    import freqdivider_prog_pkg::*;
#(
    parameter int W = FREQDIV_W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         wrap_i,
    input  logic         load_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] act_nxt_o,
    output logic         apply_o,
    output logic         busy_o
);

    localparam logic [W-1:0] DIV_MIN_W = W'(FREQDIV_DIV_MIN);

    logic [W-1:0] pend_q, pend_d;
    logic         pend_v_q, pend_v_d;
    reload_src_e  src;
    logic [W-1:0] raw;

    always_comb begin
        src      = SRC_NONE;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        // Idle and wrap edges both apply immediately; a fresh load beats the shadow.
        if (!en_i || wrap_i) begin
            if (load_i) begin
                src = SRC_DIRECT;
            end else if (pend_v_q) begin
                src = SRC_PEND;
            end
            pend_v_d = 1'b0;
        end else if (load_i) begin
            pend_d   = div_i;
            pend_v_d = 1'b1;
        end
    end

    assign raw       = (src == SRC_PEND) ? pend_q : div_i;
    assign act_nxt_o = (raw < DIV_MIN_W) ? DIV_MIN_W : raw;
    assign apply_o   = (src != SRC_NONE);
    assign busy_o    = pend_v_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

endmodule

// File: rtl/freqdivider_prog.sv
// Runtime-programmable clock-enable divider producing a near-50% square wave.
// Define FREQDIV_TICK_EN to add the registered one-cycle tick per period.
module freqdivider_prog
    import freqdivider_prog_pkg::*;
#(
    parameter int W       = FREQDIV_W_DEFAULT,
    parameter int M_RESET = 5
) (
    input  logic               clk,
    input  logic               rst,
    freqdivider_prog_if.slave  bus
);

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] ACT_RST = W'(clamp_div_int(M_RESET));

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] act_q, act_d;
    logic         clk_q, clk_d;
    logic [W-1:0] half;
    logic         wrap;
    logic [W-1:0] act_nxt;
    logic         apply;
    logic         busy;

    assign half = act_q >> 1;
    assign wrap = bus.en && (cnt_q == act_q - ONE);

    freqdivider_prog_reload #(.W(W)) u_reload (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (bus.en),
        .wrap_i    (wrap),
        .load_i    (bus.div_load),
        .div_i     (bus.div_in),
        .act_nxt_o (act_nxt),
        .apply_o   (apply),
        .busy_o    (busy)
    );

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (!bus.en || wrap) begin
            cnt_d = '0;
        end
        act_d = apply ? act_nxt : act_q;
        clk_d = bus.en && (cnt_q < half);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            act_q <= ACT_RST;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
            clk_q <= clk_d;
        end
    end

    assign bus.clk_salida = clk_q;
    assign bus.div_busy   = busy;

`ifdef FREQDIV_TICK_EN
    logic tick_q, tick_d;

    assign tick_d = bus.en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign bus.tick = tick_q;
`endif

endmodule
